// File: rtl/divider_control.sv
// divider_control: 32-bit radix-2 restoring divider for signed (DIV) and
// unsigned (DIVU) operands. The result is {remainder, quotient}.
//
// Optional feature: define DIV_ZERO_FAST_EN to finish a divide-by-zero in one
// cycle with {dividend, 32'hFFFFFFFF}. The default build runs every request,
// including divide-by-zero, through the full 34-cycle iteration path.
//
// Timing of a normal request:
//   accepting edge -> CALC for 32 edges -> FIX for 1 edge -> DONE for 1 edge.
// The DONE edge registers the done pulse and the result. The pulse is
// therefore visible in the cycle after the 34th edge, and the FSM is
// already back in IDLE during that cycle.
module divider_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_begin,
    input  logic        div_sign,
    input  logic [31:0] div_a,
    input  logic [31:0] div_b,
    output logic [63:0] div_res,
    output logic        div_done,
    output logic        div_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [5:0]  iter_cnt;
    // The mode bit is folded into these two flags when they are latched, so
    // they are only ever set for signed operations.
    logic        a_neg_q;
    logic        b_neg_q;
    logic [31:0] divisor_q;
    logic [31:0] quot_q;
    logic [31:0] rem_q;

`ifdef DIV_ZERO_FAST_EN
    // Marks an operation that already produced its done pulse on acceptance.
    logic        fast_q;
`endif

    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] part_rem;
    logic        can_sub;
    logic [31:0] rem_next;

    // Operand magnitudes; only signed mode takes absolute values.
    always_comb begin
        a_abs = (div_sign && div_a[31]) ? (32'd0 - div_a) : div_a;
        b_abs = (div_sign && div_b[31]) ? (32'd0 - div_b) : div_b;
    end

    // One restoring step: shift in the next dividend bit, then subtract
    // the divisor if it fits.
    always_comb begin
        part_rem = {rem_q, quot_q[31]};
        can_sub  = (part_rem >= {1'b0, divisor_q});
        // The remainder after a successful subtract is below the divisor,
        // so it always fits in 32 bits.
        rem_next = can_sub ? 32'(part_rem - {1'b0, divisor_q}) : part_rem[31:0];
    end

    // State register. Reset takes priority over any request at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A request is only looked at in IDLE.
    always_comb begin
        // NOTE: next_state gets its default before the case statement, so
        // no path can leave it unassigned and infer a latch.
        next_state = state;
        case (state)
            IDLE: begin
                if (div_begin) begin
`ifdef DIV_ZERO_FAST_EN
                    next_state = (div_b == 32'd0) ? DONE : CALC;
`else
                    next_state = CALC;
`endif
                end
            end
            CALC: begin
                if (iter_cnt == 6'd31) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_cnt  <= 6'd0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            divisor_q <= 32'd0;
            quot_q    <= 32'd0;
            rem_q     <= 32'd0;
            div_done  <= 1'b0;
            div_res   <= 64'h0;
`ifdef DIV_ZERO_FAST_EN
            fast_q    <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            // That way every register here samples values from before the edge.
            div_done <= 1'b0;
            div_res  <= 64'h0;
            case (state)
                IDLE: begin
                    if (div_begin) begin
                        a_neg_q   <= div_sign & div_a[31];
                        b_neg_q   <= div_sign & div_b[31];
                        divisor_q <= b_abs;
                        quot_q    <= a_abs;
                        rem_q     <= 32'd0;
                        iter_cnt  <= 6'd0;
`ifdef DIV_ZERO_FAST_EN
                        fast_q    <= (div_b == 32'd0);
                        if (div_b == 32'd0) begin
                            div_done <= 1'b1;
                            div_res  <= {div_a, 32'hFFFF_FFFF};
                        end
`endif
                    end
                end
                CALC: begin
                    iter_cnt <= iter_cnt + 6'd1;
                    quot_q   <= {quot_q[30:0], can_sub};
                    rem_q    <= rem_next;
                end
                FIX: begin
                    // Truncating division: the quotient is negative when the
                    // signs differ, and the remainder follows the dividend.
                    if (a_neg_q ^ b_neg_q) begin
                        quot_q <= 32'd0 - quot_q;
                    end
                    if (a_neg_q) begin
                        rem_q <= 32'd0 - rem_q;
                    end
                end
                DONE: begin
`ifdef DIV_ZERO_FAST_EN
                    if (!fast_q) begin
                        div_done <= 1'b1;
                        div_res  <= {rem_q, quot_q};
                    end
`else
                    div_done <= 1'b1;
                    div_res  <= {rem_q, quot_q};
`endif
                end
                default: ;
            endcase
        end
    end

    // Busy covers every non-IDLE state.
    always_comb begin
        div_busy = (state != IDLE);
    end

endmodule

// File: tb/tb_divider_control.sv
// Testbench for divider_control. Table-driven operations and hand-written
// multi-cycle sequences. Expected values are computed by hand.
module tb_divider_control;

    logic        clk;
    logic        rst;
    logic        div_begin;
    logic        div_sign;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [63:0] div_res;
    logic        div_done;
    logic        div_busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    divider_control dut (
        .clk       (clk),
        .rst       (rst),
        .div_begin (div_begin),
        .div_sign  (div_sign),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_res   (div_res),
        .div_done  (div_done),
        .div_busy  (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 0;
`else
    localparam int ZERO_LAT = 34;
`endif

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, then scramble the operands. Wait for the done pulse
    // and check latency, result, busy duration, zero output while waiting,
    // and the clean return afterwards.
    task automatic run_op(input vec_t v);
        int          lat;
        int          busy_cnt;
        bit          zero_ok;
        logic [63:0] res_at_done;
        lat         = -1;
        busy_cnt    = 0;
        zero_ok     = 1'b1;
        res_at_done = 64'h0;
        div_sign  = v.sign;
        div_a     = v.a;
        div_b     = v.b;
        div_begin = 1'b1;
        tick();
        div_begin = 1'b0;
        div_a     = ~v.a;
        div_b     = 32'h0000_0003;
        div_sign  = ~v.sign;
        for (int n = 0; n <= 60; n++) begin
            if (n > 0) tick();
            if (div_done) begin
                lat         = n;
                res_at_done = div_res;
                break;
            end
            if (div_busy) busy_cnt++;
            if (div_res !== 64'h0) zero_ok = 1'b0;
        end
        check({v.name, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({v.name, " result"}, res_at_done, v.exp_res);
        check({v.name, " busy cycles"}, 64'(busy_cnt), 64'(v.exp_lat));
        check({v.name, " res zero while busy"}, 64'(zero_ok), 64'd1);
        tick();
        check({v.name, " done drops"}, {div_done, div_res}, 65'h0);
    endtask

    vec_t vecs[10];

    initial begin
        int          done_cnt;
        int          first_done;
        int          second_done;
        bit          zero_ok;
        logic [63:0] res1;
        logic [63:0] res2;

        vecs[0] = '{"u 100/7",       1'b0, 32'd100,       32'd7,         {32'd2, 32'd14},                 34};
        vecs[1] = '{"s -7/2",        1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD},  34};
        vecs[2] = '{"s min/-1",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000},          34};
        vecs[3] = '{"u div0",        1'b0, 32'h1234_5678, 32'd0,         {32'h1234_5678, 32'hFFFF_FFFF},  ZERO_LAT};
        vecs[4] = '{"u max/1",       1'b0, 32'hFFFF_FFFF, 32'd1,         {32'h0, 32'hFFFF_FFFF},          34};
        vecs[5] = '{"s 7/-2",        1'b1, 32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD},          34};
        vecs[6] = '{"s -8/-3",       1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'd2},          34};
        vecs[7] = '{"u fff9/2",      1'b0, 32'hFFFF_FFF9, 32'd2,         {32'd1, 32'h7FFF_FFFC},          34};
        vecs[8] = '{"s 5/0",         1'b1, 32'd5,         32'd0,         {32'd5, 32'hFFFF_FFFF},          ZERO_LAT};
`ifdef DIV_ZERO_FAST_EN
        vecs[9] = '{"s -5/0",        1'b1, 32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'hFFFF_FFFF},  ZERO_LAT};
`else
        vecs[9] = '{"s -5/0",        1'b1, 32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'h0000_0001},  ZERO_LAT};
`endif

        rst = 1'b1; div_begin = 1'b0; div_sign = 1'b0; div_a = 32'd0; div_b = 32'd0;
        tick();
        tick();
        check("reset outputs", {div_done, div_busy, div_res}, 66'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i]);
        end

        // div_begin held high through the whole operation.
        div_sign = 1'b0; div_a = 32'd100; div_b = 32'd7; div_begin = 1'b1;
        tick();
        done_cnt = 0; first_done = -1; second_done = -1; zero_ok = 1'b1;
        res1 = 64'h0; res2 = 64'h0;
        for (int n = 1; n <= 80; n++) begin
            tick();
            if (n == 35) begin
                check("held begin re-accept busy", 64'(div_busy), 64'd1);
                div_begin = 1'b0;
            end
            if (div_done) begin
                done_cnt++;
                if (first_done < 0) begin first_done = n; res1 = div_res; end
                else begin second_done = n; res2 = div_res; end
            end else if (div_res !== 64'h0) begin
                zero_ok = 1'b0;
            end
        end
        check("held begin first done", 64'(first_done), 64'd34);
        check("held begin second done", 64'(second_done), 64'd69);
        check("held begin pulse count", 64'(done_cnt), 64'd2);
        check("held begin res1", res1, {32'd2, 32'd14});
        check("held begin res2", res2, {32'd2, 32'd14});
        check("held begin res zero between", 64'(zero_ok), 64'd1);

        // Reset in the middle of an operation, then a request right after.
        div_sign = 1'b1; div_a = 32'hFFFF_FFF9; div_b = 32'd2; div_begin = 1'b1;
        tick();
        div_begin = 1'b0;
        for (int n = 1; n <= 10; n++) tick();
        rst = 1'b1;
        tick();
        check("mid reset busy", {div_busy, div_done}, 2'b00);
        rst = 1'b0;
        div_sign = 1'b0; div_a = 32'd100; div_b = 32'd7; div_begin = 1'b1;
        tick();
        div_begin = 1'b0;
        done_cnt = 0; first_done = -1; res1 = 64'h0;
        for (int n = 1; n <= 50; n++) begin
            tick();
            if (div_done) begin
                done_cnt++;
                if (first_done < 0) begin first_done = n; res1 = div_res; end
            end
        end
        check("after reset done cycle", 64'(first_done), 64'd34);
        check("after reset pulse count", 64'(done_cnt), 64'd1);
        check("after reset result", res1, {32'd2, 32'd14});

        // rst and div_begin high at the same edge: the request is dropped.
        rst = 1'b1; div_begin = 1'b1;
        tick();
        rst = 1'b0; div_begin = 1'b0;
        check("rst+begin busy", 64'(div_busy), 64'd0);
        tick();
        check("rst+begin still idle", {div_busy, div_done}, 2'b00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/divider_control.md
DIVIDER_CONTROL -- requirements
Module: divider_control

Interface
REQ-001 The block SHALL have a clock input: clk, input, 1, rising-edge clock.
REQ-002 The block SHALL have a reset input: rst, input, 1; reset is synchronous and active-high.
REQ-003 The block SHALL have a start input: div_begin, input, 1, start request; sampled only in IDLE.
REQ-004 The block SHALL have a mode input: div_sign, input, 1; 1 = signed (DIV), 0 = unsigned (DIVU); latched with operands.
REQ-005 The block SHALL have a dividend input: div_a, input, 32, dividend.
REQ-006 The block SHALL have a divisor input: div_b, input, 32, divisor.
REQ-007 The block SHALL have a result output: div_res, output, 64; [63:32] = remainder (HI), [31:0] = quotient (LO).
REQ-008 The block SHALL have a completion output: div_done, output, 1, one-cycle completion pulse.
REQ-009 The block SHALL have a status output: div_busy, output, 1; high whenever the state is not IDLE.

Function
REQ-010 The block SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-011 On a rising edge in IDLE with div_begin=1, the block SHALL latch div_sign, |div_a| and |div_b| (absolute values only when div_sign=1), latch the sign bits of both operands, clear a 6-bit iteration counter, and enter CALC.
REQ-012 In CALC the block SHALL perform one radix-2 restoring iteration per cycle using a 33-bit partial remainder, for 32 cycles, then enter FIX.
REQ-013 In FIX the block SHALL apply sign correction: negate the quotient if div_sign=1 and the operand signs differ; negate the remainder if div_sign=1 and the dividend is negative. It SHALL then enter DONE.
REQ-014 In DONE the block SHALL hold div_done=1 for exactly one cycle, then return to IDLE.
REQ-015 Latency: div_done SHALL be high in the cycle following the 34th rising edge after the edge that sampled div_begin, i.e. 34 cycles from request to done pulse.
REQ-016 div_res SHALL equal the final result while div_done=1, and SHALL be 64'h0 in all other cycles.
REQ-017 Signed division SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-018 The signed case 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0x00000000 without error.
REQ-019 Divide by zero without the macro SHALL follow the full path and yield the natural algorithm result: magnitude quotient 0xFFFFFFFF and magnitude remainder |a|, with REQ-013 then applied.
REQ-020 div_begin SHALL be ignored in CALC, FIX and DONE, including the DONE cycle itself.
REQ-021 Operand inputs SHALL be don't-care after the accepting edge; changes to them SHALL NOT affect the operation in flight.

Reset
REQ-022 When rst=1 at a rising edge, the block SHALL enter IDLE and set div_done=0, div_busy=0 and div_res=64'h0, with the counter and datapath registers cleared.
REQ-023 Reset asserted mid-operation SHALL abort the division with no done pulse; a div_begin in the first cycle after reset deassertion SHALL be accepted.
REQ-024 If rst and div_begin are both high at the same edge, rst SHALL take priority and the request SHALL be dropped.

Configuration
REQ-025 When the macro DIV_ZERO_FAST_EN is defined and div_b=0 at acceptance, the block SHALL go from IDLE directly to DONE, asserting div_done in the cycle after the accepting edge with div_res = {div_a, 32'hFFFFFFFF} regardless of div_sign; sign correction SHALL NOT apply.
REQ-026 When DIV_ZERO_FAST_EN is not defined, divide by zero SHALL behave per REQ-019 with the normal 34-cycle latency.

Verification
REQ-027 Unsigned: div_sign=0, a=100, b=7, pulse div_begin -> div_done pulse 34 cycles later with div_res={32'd2, 32'd14}, and div_busy high for 34 cycles.
REQ-028 Signed: div_sign=1, a=-7 (0xFFFFFFF9), b=2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); additionally a=0x80000000, b=0xFFFFFFFF -> {32'h0, 32'h80000000}.
REQ-029 Ignored start: hold div_begin=1 continuously from an accepted start through DONE -> exactly one done pulse at cycle 34, a new operation accepted on the first IDLE edge, and div_res=0 outside the done pulses.
REQ-030 Reset mid-operation: assert rst at cycle 10 of a division -> no done pulse, div_busy=0 next cycle, and a fresh 100/7 issued afterwards completes correctly at 34 cycles.
REQ-031 Divide by zero, unsigned, a=0x12345678: with DIV_ZERO_FAST_EN -> done one cycle after acceptance with {0x12345678, 0xFFFFFFFF}; without the macro -> same value at 34 cycles.
